// File: rtl/lc3_mem_pkg.sv
// -----------------------------------------------------------------------------
// lc3_mem_pkg
// Shared definitions for the LC3 memory responder:
//   state_e           - responder FSM states (idle, wait-state countdown, response)
//   MMIO_BASE_DEFAULT - first address routed to the MMIO port instead of RAM
//   clamp_wait()      - limits a requested wait-state count to the supported max
// -----------------------------------------------------------------------------
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hFE00;

    function automatic int clamp_wait(input int cfg, input int max_wait);
        return (cfg > max_wait) ? max_wait : cfg;
    endfunction

endpackage

// File: rtl/lc3_mem_array.sv
// -----------------------------------------------------------------------------
// lc3_mem_array
// Single-port synchronous RAM: one shared address, one write port, registered
// read (read-before-write when both happen on the same edge).
// Ports:
//   clk      - clock
//   we_i     - write enable for addr_i
//   addr_i   - word index (shared by read and write)
//   wdata_i  - write data
//   rdata_o  - data at addr_i as of the previous rising edge
// -----------------------------------------------------------------------------
module lc3_mem_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the storage array has no reset; clearing it would turn the RAM
    // into thousands of flops and stop it mapping onto a memory macro.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3_mem_model.sv
// -----------------------------------------------------------------------------
// lc3_mem_model
// Memory responder for the LC3 core's memory port, with run-time wait states,
// an MMIO window routed to a separate port, and a backdoor preload port.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   memEN, memWE           - core request strobe and write select
//   memory_addr/din/dout   - core address, write data, read data
//   memRDY                 - one-cycle completion pulse
//   wait_cfg               - wait states per access (clamped to MAX_WAIT)
//   mmio_we/re             - one-cycle MMIO write/read pulses in the response cycle
//   mmio_addr/wdata        - latched MMIO address and write data
//   mmio_rdata             - MMIO read data, sampled in the response cycle
//   bd_we/addr/data        - backdoor RAM write
//   bd_busy                - backdoor write refused this cycle
// -----------------------------------------------------------------------------
module lc3_mem_model
    import lc3_mem_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 16,
    parameter int                DEPTH_LOG2 = 12,
    parameter int                MAX_WAIT   = 7,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = ADDR_W'(MMIO_BASE_DEFAULT),
    localparam int               WAIT_W     = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memEN,
    input  logic                  memWE,
    input  logic [ADDR_W-1:0]     memory_addr,
    input  logic [DATA_W-1:0]     memory_din,
    output logic [DATA_W-1:0]     memory_dout,
    output logic                  memRDY,
    input  logic [WAIT_W-1:0]     wait_cfg,
    output logic                  mmio_we,
    output logic                  mmio_re,
    output logic [ADDR_W-1:0]     mmio_addr,
    output logic [DATA_W-1:0]     mmio_wdata,
    input  logic [DATA_W-1:0]     mmio_rdata,
    input  logic                  bd_we,
    input  logic [DEPTH_LOG2-1:0] bd_addr,
    input  logic [DATA_W-1:0]     bd_data,
    output logic                  bd_busy
);

    state_e                state_q, state_d;
    logic [WAIT_W-1:0]     cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]     din_q, din_d;
    logic                  we_q, we_d;
    logic                  mmio_q, mmio_d;
    logic [ADDR_W-1:0]     mmio_addr_q, mmio_addr_d;
    logic [DATA_W-1:0]     mmio_wdata_q, mmio_wdata_d;
    logic [DATA_W-1:0]     dout_q, dout_d;

    logic [WAIT_W-1:0]     wait_clamped;
    logic                  req_mmio;
    logic                  in_resp;
    logic                  resp_read;
    logic                  bd_accept;
    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;
    logic [DATA_W-1:0]     read_val;

    assign wait_clamped = WAIT_W'(clamp_wait(int'(wait_cfg), MAX_WAIT));
    assign req_mmio     = (memory_addr >= MMIO_BASE);

    // A reset landing on the response cycle suppresses every visible effect
    // of that cycle: no completion pulse, no MMIO pulse, no RAM write.
    assign in_resp   = (state_q == ST_RESP) && !rst;
    assign resp_read = in_resp && !we_q;
    assign read_val  = mmio_q ? mmio_rdata : ram_rdata;

    // Backdoor only gets the RAM when the core neither owns nor is claiming it.
    assign bd_accept = bd_we && (state_q == ST_IDLE) && !memEN;
    assign bd_busy   = bd_we && !bd_accept;

    // In IDLE the incoming address feeds the RAM directly so that read data is
    // already registered when a zero-wait access reaches RESP one cycle later.
    assign ram_addr  = (state_q != ST_IDLE) ? idx_q :
                       memEN                ? memory_addr[DEPTH_LOG2-1:0] : bd_addr;
    assign ram_we    = (in_resp && we_q && !mmio_q) || bd_accept;
    assign ram_wdata = bd_accept ? bd_data : din_q;

    lc3_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign memRDY      = in_resp;
    assign mmio_we     = in_resp && we_q && mmio_q;
    assign mmio_re     = in_resp && !we_q && mmio_q;
    assign mmio_addr   = mmio_addr_q;
    assign mmio_wdata  = mmio_wdata_q;
    assign memory_dout = resp_read ? read_val : dout_q;

    // NOTE: every variable is given its hold value before the case statement,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        din_d        = din_q;
        we_d         = we_q;
        mmio_d       = mmio_q;
        mmio_addr_d  = mmio_addr_q;
        mmio_wdata_d = mmio_wdata_q;
        dout_d       = dout_q;

        case (state_q)
            ST_IDLE: begin
                if (memEN) begin
                    idx_d  = memory_addr[DEPTH_LOG2-1:0];
                    din_d  = memory_din;
                    we_d   = memWE;
                    mmio_d = req_mmio;
                    cnt_d  = wait_clamped;
                    if (req_mmio) begin
                        mmio_addr_d = memory_addr;
                        if (memWE) begin
                            mmio_wdata_d = memory_din;
                        end
                    end
                    state_d = (wait_clamped != '0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - WAIT_W'(1);
                if (cnt_q == WAIT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!we_q) begin
                    dout_d = read_val;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
            mmio_q       <= 1'b0;
            mmio_addr_q  <= '0;
            mmio_wdata_q <= '0;
            dout_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            din_q        <= din_d;
            we_q         <= we_d;
            mmio_q       <= mmio_d;
            mmio_addr_q  <= mmio_addr_d;
            mmio_wdata_q <= mmio_wdata_d;
            dout_q       <= dout_d;
        end
    end

endmodule

// File: tb/tb_lc3_mem_model.sv
// -----------------------------------------------------------------------------
// tb_lc3_mem_model
// Self-checking bench for lc3_mem_model. MAX_WAIT is set to 5 so that the
// 3-bit wait_cfg port can carry values (6, 7) that must be clamped.
// The reference model is a plain word array plus the last read value; every
// access computes its expected latency and data straight from the rules.
// -----------------------------------------------------------------------------
module tb_lc3_mem_model;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int DEPTH_LOG2 = 12;
    localparam int MAX_WAIT   = 5;
    localparam int WAIT_W     = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  memEN;
    logic                  memWE;
    logic [ADDR_W-1:0]     memory_addr;
    logic [DATA_W-1:0]     memory_din;
    logic [DATA_W-1:0]     memory_dout;
    logic                  memRDY;
    logic [WAIT_W-1:0]     wait_cfg;
    logic                  mmio_we;
    logic                  mmio_re;
    logic [ADDR_W-1:0]     mmio_addr;
    logic [DATA_W-1:0]     mmio_wdata;
    logic [DATA_W-1:0]     mmio_rdata;
    logic                  bd_we;
    logic [DEPTH_LOG2-1:0] bd_addr;
    logic [DATA_W-1:0]     bd_data;
    logic                  bd_busy;

    always #5 clk = ~clk;

    lc3_mem_model #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .MAX_WAIT   (MAX_WAIT),
        .MMIO_BASE  (16'hFE00)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memEN       (memEN),
        .memWE       (memWE),
        .memory_addr (memory_addr),
        .memory_din  (memory_din),
        .memory_dout (memory_dout),
        .memRDY      (memRDY),
        .wait_cfg    (wait_cfg),
        .mmio_we     (mmio_we),
        .mmio_re     (mmio_re),
        .mmio_addr   (mmio_addr),
        .mmio_wdata  (mmio_wdata),
        .mmio_rdata  (mmio_rdata),
        .bd_we       (bd_we),
        .bd_addr     (bd_addr),
        .bd_data     (bd_data),
        .bd_busy     (bd_busy)
    );

    // Reference model
    logic [15:0] mem_m [4096];
    logic [15:0] dout_m;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Backdoor write; leaves bd_we high so the next driver decides the next cycle.
    task automatic bd_write(input logic [11:0] idx, input logic [15:0] data);
        @(negedge clk);
        memEN   = 1'b0;
        bd_we   = 1'b1;
        bd_addr = idx;
        bd_data = data;
        #1;
        check("bd_busy_idle", 32'(bd_busy), 0);
        mem_m[idx] = data;
    endtask

    // One core access, checked for latency, data, MMIO pulses and pulse width.
    task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] din,
                          input logic [2:0] wcfg, input logic [15:0] mrd, input logic bd_clash);
        int          exp_lat;
        int          lat;
        logic        is_mmio;
        logic [11:0] idx;
        logic [15:0] exp_dout;
        is_mmio = (addr >= 16'hFE00);
        idx     = addr[11:0];
        exp_lat = 1 + ((int'(wcfg) > MAX_WAIT) ? MAX_WAIT : int'(wcfg));

        @(negedge clk);
        memEN       = 1'b1;
        memWE       = we;
        memory_addr = addr;
        memory_din  = din;
        wait_cfg    = wcfg;
        mmio_rdata  = 16'($urandom);
        bd_we       = bd_clash;
        bd_addr     = idx;
        bd_data     = ~mem_m[idx];
        #1;
        check("rdy_at_req", 32'(memRDY), 0);
        if (bd_clash) check("bd_busy_req", 32'(bd_busy), 1);

        lat = 0;
        do begin
            @(negedge clk);
            // Everything the core drives after acceptance must be ignored.
            memEN       = 1'b0;
            bd_we       = 1'b0;
            memWE       = 1'($urandom);
            memory_addr = 16'($urandom);
            memory_din  = 16'($urandom);
            wait_cfg    = 3'($urandom);
            lat++;
            mmio_rdata  = (lat == exp_lat) ? mrd : 16'($urandom);
            #1;
        end while (!memRDY && lat < 30);

        check("latency", 32'(lat), 32'(exp_lat));
        if (memRDY) begin
            exp_dout = we ? dout_m : (is_mmio ? mrd : mem_m[idx]);
            check("dout", 32'(memory_dout), 32'(exp_dout));
            check("mmio_we", 32'(mmio_we), 32'(we & is_mmio));
            check("mmio_re", 32'(mmio_re), 32'(!we & is_mmio));
            if (is_mmio && we) begin
                check("mmio_addr", 32'(mmio_addr), 32'(addr));
                check("mmio_wdata", 32'(mmio_wdata), 32'(din));
            end
            dout_m = exp_dout;
            if (we && !is_mmio) mem_m[idx] = din;
        end

        @(negedge clk);
        #1;
        check("rdy_pulse", 32'(memRDY), 0);
        check("mmio_quiet", 32'({mmio_we, mmio_re}), 0);
        check("dout_hold", 32'(memory_dout), 32'(dout_m));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int first;
        int w;

        rst         = 1'b1;
        memEN       = 1'b0;
        memWE       = 1'b0;
        memory_addr = '0;
        memory_din  = '0;
        wait_cfg    = '0;
        mmio_rdata  = '0;
        bd_we       = 1'b0;
        bd_addr     = '0;
        bd_data     = '0;
        dout_m      = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rdy", 32'(memRDY), 0);
        check("rst_mmio_we", 32'(mmio_we), 0);
        check("rst_mmio_re", 32'(mmio_re), 0);
        check("rst_dout", 32'(memory_dout), 0);
        check("rst_mmio_addr", 32'(mmio_addr), 0);
        check("rst_mmio_wdata", 32'(mmio_wdata), 0);

        // Preload every word so the model is fully known.
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk);
            bd_we   = 1'b1;
            bd_addr = 12'(i);
            bd_data = 16'($urandom);
            mem_m[i] = bd_data;
        end

        // Zero-wait read right after a backdoor write.
        bd_write(12'h000, 16'h1234);
        access(1'b0, 16'h3000, 16'h0000, 3'd0, 16'h0, 1'b0);

        // Three wait states, write then read back.
        access(1'b1, 16'h3001, 16'hBEEF, 3'd3, 16'h0, 1'b0);
        access(1'b0, 16'h3001, 16'h0000, 3'd3, 16'h0, 1'b0);

        // wait_cfg above MAX_WAIT clamps.
        access(1'b0, 16'h3001, 16'h0000, 3'd7, 16'h0, 1'b0);
        access(1'b1, 16'h3003, 16'h0F0F, 3'd6, 16'h0, 1'b0);
        access(1'b0, 16'h3003, 16'h0000, 3'd5, 16'h0, 1'b0);

        // MMIO write leaves RAM alone, MMIO read returns the sampled port.
        access(1'b1, 16'hFE02, 16'h0041, 3'd1, 16'h0, 1'b0);
        access(1'b0, 16'h0E02, 16'h0000, 3'd0, 16'h0, 1'b0);
        access(1'b0, 16'hFE00, 16'h0000, 3'd2, 16'h8000, 1'b0);
        access(1'b0, 16'hFFFF, 16'h0000, 3'd0, 16'h7E57, 1'b0);

        // Aliasing above the RAM depth.
        bd_write(12'h005, 16'h00AA);
        access(1'b0, 16'h1005, 16'h0000, 3'd1, 16'h0, 1'b0);

        // Backdoor refused while the core is requesting.
        access(1'b0, 16'h3000, 16'h0000, 3'd1, 16'h0, 1'b1);

        // Held memEN: one access per 2+wait cycles.
        w      = 2;
        pulses = 0;
        first  = -1;
        for (int c = 0; c < 4 * (2 + w); c++) begin
            @(negedge clk);
            memEN       = 1'b1;
            memWE       = 1'b0;
            memory_addr = 16'h3000;
            wait_cfg    = 3'(w);
            bd_we       = 1'b0;
            #1;
            if (memRDY) begin
                pulses++;
                if (first < 0) first = c;
                check("hold_dout", 32'(memory_dout), 32'(mem_m[0]));
            end
        end
        @(negedge clk);
        memEN = 1'b0;
        check("hold_pulses", 32'(pulses), 4);
        check("hold_first", 32'(first), 32'(1 + w));
        dout_m = mem_m[0];

        // Reset during WAIT aborts a write; backdoor refused during WAIT.
        bd_write(12'h002, 16'h0000);
        @(negedge clk);
        bd_we       = 1'b0;
        memEN       = 1'b1;
        memWE       = 1'b1;
        memory_addr = 16'h3002;
        memory_din  = 16'hDEAD;
        wait_cfg    = 3'd4;
        @(negedge clk);
        memEN = 1'b0;
        #1;
        check("abort_wait_rdy", 32'(memRDY), 0);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = 12'h002;
        bd_data = 16'h5555;
        #1;
        check("bd_busy_wait", 32'(bd_busy), 1);
        @(negedge clk);
        bd_we = 1'b0;
        rst   = 1'b1;
        #1;
        check("rdy_in_rst", 32'(memRDY), 0);
        @(negedge clk);
        rst    = 1'b0;
        dout_m = '0;
        #1;
        check("post_rst_dout", 32'(memory_dout), 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check("abort_quiet", 32'({memRDY, mmio_we, mmio_re}), 0);
        end
        access(1'b0, 16'h3002, 16'h0000, 3'd0, 16'h0, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            logic [15:0] a;
            if ($urandom_range(0, 3) == 0) a = 16'hFE00 | 16'($urandom_range(0, 511));
            else                           a = 16'($urandom_range(0, 16'hFDFF));
            if ($urandom_range(0, 5) == 0) bd_write(12'($urandom), 16'($urandom));
            access(1'($urandom), a, 16'($urandom), 3'($urandom), 16'($urandom),
                   ($urandom_range(0, 7) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
